// File: rtl/quad_input_filter_if.sv
// quad_input_filter_if: raw encoder pins in, filtered levels and step/dir/err events out.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a plain level or single-cycle pulse.
interface quad_input_filter_if #(
    parameter int ERR_W = 8
);
    logic             a_in;
    logic             b_in;
    logic             z_in;
    logic             err_clr;
    logic             a;
    logic             b;
    logic             z;
    logic             step;
    logic             dir;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    // Encoder/host side: drives pins and clear, observes conditioned outputs.
    modport master (
        output a_in, b_in, z_in, err_clr,
        input  a, b, z, step, dir, err, err_cnt
    );

    // Filter side.
    modport slave (
        input  a_in, b_in, z_in, err_clr,
        output a, b, z, step, dir, err, err_cnt
    );
endinterface

// File: rtl/quad_input_filter.sv
// quad_input_filter: 2-flop sync plus per-phase stability filter for A/B/Z, emitting step/dir/err events.
// Latency: a stable pin change reaches a/b/z on the (FILTER_LEN+2)-th edge, counting the sampling edge as the first.
// Backpressure: none, free-running; optional macro QUAD_INDEX_GATE_EN gates z with the A=B=1 quadrant.
module quad_input_filter #(
    parameter int FILTER_LEN = 4,
    parameter int ERR_W      = 8
) (
    input logic                clk,
    input logic                rst_n,
    quad_input_filter_if.slave bus
);

    localparam int CNT_W = $clog2(FILTER_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

    // Two warm-up edges after reset before the filter takes over.
    typedef enum logic [1:0] {
        PR_EDGE1,
        PR_EDGE2,
        PR_RUN
    } prime_e;

    // Channel index: 0 = A, 1 = B, 2 = Z.
    logic [2:0]       raw;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       filt_q;
    logic [2:0]       filt_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    prime_e           prime_q;
    logic             primed;
    logic             a_chg;
    logic             b_chg;
    logic             step_q;
    logic             step_d;
    logic             dir_q;
    logic             dir_d;
    logic             err_q;
    logic             err_d;
    logic [ERR_W-1:0] err_cnt_q;
    logic [ERR_W-1:0] err_cnt_d;

    assign raw    = {bus.z_in, bus.b_in, bus.a_in};
    assign primed = (prime_q == PR_RUN);

    // Per-channel run-length filter: follow the synced level only after it has
    // disagreed with the filtered level for FILTER_LEN consecutive edges.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Step/err classification from the A/B transitions landing on this edge.
    always_comb begin
        a_chg  = filt_d[0] ^ filt_q[0];
        b_chg  = filt_d[1] ^ filt_q[1];
        step_d = primed & (a_chg ^ b_chg);
        err_d  = primed & a_chg & b_chg;
        // Forward when the new B differs from the old A.
        dir_d  = step_d ? (filt_d[1] ^ filt_q[0]) : dir_q;
        // A clear coinciding with an error keeps that error counted.
        err_cnt_d = err_cnt_q;
        if (bus.err_clr) begin
            err_cnt_d = ERR_W'(err_d);
        end else if (err_d && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
        end
    end

    // Synchronisers, priming sequence, filter state and registered events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            filt_q    <= '0;
            cnt_q     <= '{default: '0};
            prime_q   <= PR_EDGE1;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            err_cnt_q <= err_cnt_d;
            case (prime_q)
                PR_EDGE1: prime_q <= PR_EDGE2;
                PR_EDGE2: begin
                    // Load the value the second sync stage takes on this edge,
                    // so the filtered level starts equal to the pins.
                    filt_q  <= sync1_q;
                    prime_q <= PR_RUN;
                end
                default: begin
                    filt_q <= filt_d;
                    cnt_q  <= cnt_d;
                    step_q <= step_d;
                    err_q  <= err_d;
                    dir_q  <= dir_d;
                end
            endcase
        end
    end

    assign bus.a       = filt_q[0];
    assign bus.b       = filt_q[1];
    assign bus.step    = step_q;
    assign bus.dir     = dir_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;

`ifdef QUAD_INDEX_GATE_EN
    // Index only reported in the A=B=1 quadrant.
    assign bus.z = filt_q[2] & filt_q[0] & filt_q[1];
`else
    assign bus.z = filt_q[2];
`endif

endmodule
